mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits between the compute cores' per-thread data-cache memory ports and the external data memory.
- Multiplexes NUM_CONSUMERS read/write requesters onto NUM_CHANNELS memory channels.
- Each consumer is one thread's dcache memory-side port. Requests are granted round-robin, and each channel relays exactly one transaction at a time.
- Replaces direct per-thread memory wiring so that many threads can share few memory channels.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 8, number of requesters (cores x threads)
- NUM_CHANNELS, 2, number of concurrent memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read address; consumer c at bits [c*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read complete
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  returned data; valid while ready=1
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write complete
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read done
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  channel write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write done
- grant_count  out  NUM_CHANNELS*32  per-channel completed transactions (see optional feature)
- stall_cycles  out  32  cycles with at least one pending, unserved request (see optional feature)

Behaviour:
- Reset (asynchronous, active-high):
  - all outputs 0
  - all channels IDLE
  - all consumer busy flags clear
  - round-robin pointer rr_ptr = 0
- Per-channel FSM has states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Scan consumers starting at rr_ptr, modulo NUM_CONSUMERS.
  - Take the first consumer with (read_valid | write_valid) whose busy flag is clear.
  - If that consumer asserts both, read wins; the write stays pending.
  - On grant: set the busy flag, latch the consumer index, and drive the latched address/data onto the channel next cycle with mem_*_valid=1.
  - Go to READ_WAIT or WRITE_WAIT.
- Multi-channel grants: channels are evaluated in index order within one cycle. A consumer claimed by a lower channel that cycle is invisible to higher channels, so no double grant is possible.
- READ_WAIT: hold mem_read_valid until mem_read_ready=1. Then:
  - clear mem_read_valid
  - set consumer_read_ready[c]=1 and consumer_read_data[c]=mem_read_data
  - go to RELAY
- WRITE_WAIT: same sequence using the write signals; no data is returned.
- RELAY:
  - Hold consumer_*_ready[c]=1 until the consumer deasserts the matching valid.
  - Then clear ready and the busy flag, and return to IDLE.
  - The channel can grant again on the cycle after it returns to IDLE.
- rr_ptr update: after any grant, rr_ptr = (last granted index + 1) mod NUM_CONSUMERS. This wraps from NUM_CONSUMERS-1 to 0.
- Latency:
  - Request to mem_*_valid: 2 cycles (grant cycle + drive cycle) when a channel is idle.
  - mem_ready to consumer_ready: 1 cycle.
- Address and data are latched at grant. Changes on the consumer bus afterwards are ignored until RELAY exits.
- All channels busy: pending requests wait; no request is dropped.
- Reset mid-transaction aborts everything immediately. Memory must tolerate mem_*_valid falling without a ready.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - grant_count[ch] increments on each RELAY->IDLE exit.
  - stall_cycles increments each cycle in which some consumer has valid=1, its busy flag is clear, and it is not granted.
  - Both counters are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: grant_count and stall_cycles are tied to 0, with no counter flops.

Test Plan:
- Single read: consumer 3 reads addr 0x2A; memory returns 0x5C after 3 cycles -> mem_read_valid[0] at cycle 2, then consumer_read_ready[3]=1 with data 0x5C one cycle after mem_read_ready; ready clears after valid drops.
- Contention, NUM_CHANNELS=2: consumers 0, 1, 2 all read at once -> channel0 serves 0, channel1 serves 1; consumer 2 is served after the first completion; stall_cycles>0 with MEM_ARB_STATS_EN.
- Round-robin fairness, NUM_CHANNELS=1: consumers 0 and 7 request continuously -> grant order 0,7,0,7; rr_ptr wraps 7->0.
- Read+write on the same consumer: consumer 5 asserts both -> read completes first, then the write (addr 0x10, data 0xAB) appears on mem_write_* with mem_write_valid=1.
- Latching: consumer changes read address 0x04->0x08 after grant -> mem_read_address stays 0x04.
- Reset mid-transaction while in WRITE_WAIT -> all valid/ready outputs go 0 asynchronously; after reset release the next grant starts at consumer 0; counters read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing per-thread dcache memory ports across NUM_CHANNELS memory channels.
// Define MEM_ARB_STATS_EN to enable the grant_count / stall_cycles counters (tied to 0 otherwise).
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [NUM_CHANNELS*32-1:0]         grant_count,
    output logic [31:0]                        stall_cycles
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                   r_state     [NUM_CHANNELS];
    state_t                   w_state_nxt [NUM_CHANNELS];
    logic [CW-1:0]            r_cidx      [NUM_CHANNELS];
    logic                     r_is_wr     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     r_addr      [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     r_wdata     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  r_mrv, r_mwv;
    logic [NUM_CONSUMERS-1:0] r_busy, r_crr, r_cwr;
    logic [DATA_BITS-1:0]     r_crd       [NUM_CONSUMERS];
    logic [CW-1:0]            r_rr_ptr;

    logic [NUM_CHANNELS-1:0]  w_gnt, w_gnt_rd, w_done, w_exit;
    logic [CW-1:0]            w_gnt_idx   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] w_req, w_claim;
    logic [CW-1:0]            w_rr_nxt, w_c;

    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CONSUMERS) s -= NUM_CONSUMERS;
        return s[CW-1:0];
    endfunction

    assign w_req = consumer_read_valid | consumer_write_valid;

    // Channels are scanned in index order; w_claim hides consumers already taken this cycle.
    always_comb begin
        w_claim  = '0;
        w_gnt    = '0;
        w_gnt_rd = '0;
        w_done   = '0;
        w_exit   = '0;
        w_rr_nxt = r_rr_ptr;
        w_c      = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            w_gnt_idx[ch]   = '0;
            case (r_state[ch])
                IDLE: begin
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        w_c = wrap_idx(r_rr_ptr, i);
                        if (!w_gnt[ch] && w_req[w_c] && !r_busy[w_c] && !w_claim[w_c]) begin
                            w_gnt[ch]       = 1'b1;
                            w_gnt_idx[ch]   = w_c;
                            w_gnt_rd[ch]    = consumer_read_valid[w_c];
                            w_claim[w_c]    = 1'b1;
                            w_rr_nxt        = wrap_idx(w_c, 1);
                            w_state_nxt[ch] = consumer_read_valid[w_c] ? READ_WAIT : WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: if (r_mrv[ch] && mem_read_ready[ch]) begin
                    w_done[ch]      = 1'b1;
                    w_state_nxt[ch] = RELAY;
                end
                WRITE_WAIT: if (r_mwv[ch] && mem_write_ready[ch]) begin
                    w_done[ch]      = 1'b1;
                    w_state_nxt[ch] = RELAY;
                end
                RELAY: if (r_is_wr[ch] ? !consumer_write_valid[r_cidx[ch]]
                                       : !consumer_read_valid[r_cidx[ch]]) begin
                    w_exit[ch]      = 1'b1;
                    w_state_nxt[ch] = IDLE;
                end
                default: w_state_nxt[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) r_state[ch] <= IDLE;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) r_state[ch] <= w_state_nxt[ch];
        end
    end

    // mem_*_valid rises on the first cycle in *_WAIT, giving the grant + drive latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_busy   <= '0;
            r_crr    <= '0;
            r_cwr    <= '0;
            r_mrv    <= '0;
            r_mwv    <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_cidx[ch]  <= '0;
                r_is_wr[ch] <= 1'b0;
                r_addr[ch]  <= '0;
                r_wdata[ch] <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) r_crd[c] <= '0;
        end else begin
            r_rr_ptr <= w_rr_nxt;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (w_gnt[ch]) begin
                    r_cidx[ch]            <= w_gnt_idx[ch];
                    r_is_wr[ch]           <= !w_gnt_rd[ch];
                    r_addr[ch]            <= w_gnt_rd[ch]
                        ? consumer_read_address[w_gnt_idx[ch]*ADDR_BITS +: ADDR_BITS]
                        : consumer_write_address[w_gnt_idx[ch]*ADDR_BITS +: ADDR_BITS];
                    r_wdata[ch]           <= consumer_write_data[w_gnt_idx[ch]*DATA_BITS +: DATA_BITS];
                    r_busy[w_gnt_idx[ch]] <= 1'b1;
                end
                if (r_state[ch] == READ_WAIT && !r_mrv[ch]) r_mrv[ch] <= 1'b1;
                if (r_state[ch] == WRITE_WAIT && !r_mwv[ch]) r_mwv[ch] <= 1'b1;
                if (w_done[ch] && r_state[ch] == READ_WAIT) begin
                    r_mrv[ch]         <= 1'b0;
                    r_crr[r_cidx[ch]] <= 1'b1;
                    r_crd[r_cidx[ch]] <= mem_read_data[ch*DATA_BITS +: DATA_BITS];
                end
                if (w_done[ch] && r_state[ch] == WRITE_WAIT) begin
                    r_mwv[ch]         <= 1'b0;
                    r_cwr[r_cidx[ch]] <= 1'b1;
                end
                if (w_exit[ch]) begin
                    r_busy[r_cidx[ch]] <= 1'b0;
                    r_crr[r_cidx[ch]]  <= 1'b0;
                    r_cwr[r_cidx[ch]]  <= 1'b0;
                end
            end
        end
    end

    assign mem_read_valid       = r_mrv;
    assign mem_write_valid      = r_mwv;
    assign consumer_read_ready  = r_crr;
    assign consumer_write_ready = r_cwr;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign mem_read_address[g*ADDR_BITS +: ADDR_BITS]  = r_addr[g];
        assign mem_write_address[g*ADDR_BITS +: ADDR_BITS] = r_addr[g];
        assign mem_write_data[g*DATA_BITS +: DATA_BITS]    = r_wdata[g];
    end

    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_cons
        assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = r_crd[g];
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_gcnt [NUM_CHANNELS];
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) r_gcnt[ch] <= '0;
        end else begin
            if (|(w_req & ~r_busy & ~w_claim)) r_stall <= r_stall + 32'd1;
            for (int ch = 0; ch < NUM_CHANNELS; ch++)
                if (w_exit[ch]) r_gcnt[ch] <= r_gcnt[ch] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_gcnt
        assign grant_count[g*32 +: 32] = r_gcnt[g];
    end
    assign stall_cycles = r_stall;
`else
    assign grant_count  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-channel instance for most cases, a 1-channel one for round-robin order.
module tb_mem_arbiter;
    localparam int AB = 8, DB = 8, NC = 8, NCH = 2;
`ifdef MEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]    crv, cwv;
    logic [NC*AB-1:0] cra, cwa;
    logic [NC*DB-1:0] cwd;

    logic [NC-1:0]     crr0, cwr0;
    logic [NC*DB-1:0]  crd0;
    logic [NCH-1:0]    mrv0, mrr0, mwv0, mwr0;
    logic [NCH*AB-1:0] mra0, mwa0;
    logic [NCH*DB-1:0] mrd0, mwd0;
    logic [NCH*32-1:0] gc0;
    logic [31:0]       st0;

    logic [NC-1:0]    crr1, cwr1;
    logic [NC*DB-1:0] crd1;
    logic             mrv1, mrr1, mwv1, mwr1;
    logic [AB-1:0]    mra1, mwa1;
    logic [DB-1:0]    mrd1, mwd1;
    logic [31:0]      gc1, st1;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) u_dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr0), .consumer_read_data(crd0),
        .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
        .consumer_write_ready(cwr0),
        .mem_read_valid(mrv0), .mem_read_address(mra0), .mem_read_ready(mrr0), .mem_read_data(mrd0),
        .mem_write_valid(mwv0), .mem_write_address(mwa0), .mem_write_data(mwd0), .mem_write_ready(mwr0),
        .grant_count(gc0), .stall_cycles(st0)
    );

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr1), .consumer_read_data(crd1),
        .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
        .consumer_write_ready(cwr1),
        .mem_read_valid(mrv1), .mem_read_address(mra1), .mem_read_ready(mrr1), .mem_read_data(mrd1),
        .mem_write_valid(mwv1), .mem_write_address(mwa1), .mem_write_data(mwd1), .mem_write_ready(mwr1),
        .grant_count(gc1), .stall_cycles(st1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0;
        mrr0 = '0; mwr0 = '0; mrd0 = '0;
        mrr1 = 1'b0; mwr1 = 1'b0; mrd1 = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [AB-1:0] exp_rr [4];
    int wait_n;
    logic [AB-1:0] got_a;

    initial begin
        exp_rr[0] = 8'h30; exp_rr[1] = 8'h37; exp_rr[2] = 8'h30; exp_rr[3] = 8'h37;
        do_reset();
        chk("rst_mrv", 32'(mrv0), 32'h0);
        chk("rst_mwv", 32'(mwv0), 32'h0);
        chk("rst_crr", 32'(crr0), 32'h0);
        chk("rst_gc", gc0[31:0], 32'h0);
        chk("rst_stall", st0, 32'h0);

        // single read, consumer 3
        crv[3] = 1'b1; cra[3*AB +: AB] = 8'h2A;
        step();
        chk("rd_grant_nomrv", 32'(mrv0), 32'h0);
        step();
        chk("rd_mrv", 32'(mrv0), 32'h1);
        chk("rd_addr", 32'(mra0[7:0]), 32'h2A);
        step();
        step();
        chk("rd_hold", 32'(mrv0), 32'h1);
        mrr0 = 2'b01; mrd0[7:0] = 8'h5C;
        step();
        mrr0 = '0;
        chk("rd_crr", 32'(crr0), 32'h08);
        chk("rd_data", 32'(crd0[3*DB +: DB]), 32'h5C);
        chk("rd_mrv_clr", 32'(mrv0), 32'h0);
        step();
        chk("rd_relay", 32'(crr0), 32'h08);
        crv[3] = 1'b0;
        step();
        chk("rd_crr_clr", 32'(crr0), 32'h0);
        chk("rd_gc", gc0[31:0], STATS ? 32'd1 : 32'd0);

        // contention across two channels
        do_reset();
        crv = 8'h07;
        cra[0 +: AB] = 8'h10; cra[AB +: AB] = 8'h11; cra[2*AB +: AB] = 8'h12;
        step();
        step();
        chk("ct_mrv", 32'(mrv0), 32'h3);
        chk("ct_addr", 32'(mra0), 32'h1110);
        mrr0 = 2'b01; mrd0[7:0] = 8'hA0;
        step();
        mrr0 = '0;
        chk("ct_crr", 32'(crr0), 32'h01);
        chk("ct_data0", 32'(crd0[7:0]), 32'hA0);
        chk("ct_mrv_ch1", 32'(mrv0), 32'h2);
        crv[0] = 1'b0;
        step();
        step();
        step();
        chk("ct_c2_mrv", 32'(mrv0), 32'h3);
        chk("ct_c2_addr", 32'(mra0[7:0]), 32'h12);
        chk("ct_stall", st0, STATS ? 32'd4 : 32'd0);

        // round-robin on the single-channel instance, 0 and 7 always requesting
        do_reset();
        crv[0] = 1'b1; crv[7] = 1'b1;
        cra[0 +: AB] = 8'h30; cra[7*AB +: AB] = 8'h37;
        for (int k = 0; k < 4; k++) begin
            wait_n = 0;
            while (!mrv1 && wait_n < 20) begin
                step();
                wait_n++;
            end
            chk("rr_timeout", 32'(wait_n < 20), 32'h1);
            got_a = mra1;
            chk($sformatf("rr_order%0d", k), 32'(got_a), 32'(exp_rr[k]));
            mrr1 = 1'b1; mrd1 = 8'h99;
            step();
            mrr1 = 1'b0;
            crv[got_a[2:0]] = 1'b0;
            step();
            crv[got_a[2:0]] = 1'b1;
        end

        // read and write on the same consumer: read first
        do_reset();
        crv[5] = 1'b1; cra[5*AB +: AB] = 8'h40;
        cwv[5] = 1'b1; cwa[5*AB +: AB] = 8'h10; cwd[5*DB +: DB] = 8'hAB;
        step();
        step();
        chk("rw_mrv", 32'(mrv0), 32'h1);
        chk("rw_mwv_idle", 32'(mwv0), 32'h0);
        mrr0 = 2'b01; mrd0[7:0] = 8'h77;
        step();
        mrr0 = '0;
        chk("rw_crr", 32'(crr0), 32'h20);
        chk("rw_rdata", 32'(crd0[5*DB +: DB]), 32'h77);
        chk("rw_cwr_idle", 32'(cwr0), 32'h0);
        crv[5] = 1'b0;
        step();
        step();
        step();
        chk("rw_mwv", 32'(mwv0), 32'h1);
        chk("rw_waddr", 32'(mwa0[7:0]), 32'h10);
        chk("rw_wdata", 32'(mwd0[7:0]), 32'hAB);
        mwr0 = 2'b01;
        step();
        mwr0 = '0;
        chk("rw_cwr", 32'(cwr0), 32'h20);
        cwv[5] = 1'b0;
        step();
        chk("rw_cwr_clr", 32'(cwr0), 32'h0);
        chk("rw_gc", gc0[31:0], STATS ? 32'd2 : 32'd0);
        chk("rw_stall", st0, 32'h0);

        // address latched at grant
        do_reset();
        crv[4] = 1'b1; cra[4*AB +: AB] = 8'h04;
        step();
        cra[4*AB +: AB] = 8'h08;
        step();
        chk("lat_mrv", 32'(mrv0), 32'h1);
        chk("lat_addr", 32'(mra0[7:0]), 32'h04);

        // reset in WRITE_WAIT, then grant order restarts at 0
        do_reset();
        cwv[2] = 1'b1; cwa[2*AB +: AB] = 8'h55; cwd[2*DB +: DB] = 8'h66;
        step();
        step();
        chk("ab_mwv", 32'(mwv0), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("ab_mwv_async", 32'(mwv0), 32'h0);
        chk("ab_cwr_async", 32'(cwr0), 32'h0);
        clr_inputs();
        step();
        reset = 1'b0;
        chk("ab_gc", gc0[31:0], 32'h0);
        chk("ab_stall", st0, 32'h0);
        crv[1] = 1'b1; crv[7] = 1'b1;
        cra[AB +: AB] = 8'h71; cra[7*AB +: AB] = 8'h77;
        step();
        step();
        chk("ab_rr_addr", 32'(mra0), 32'h7771);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
